pipeline_div_seq: RTL and testbench
===================================

PIPELINE_DIV_SEQ -- requirements
Module: pipeline_div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand and result width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: EX stage presents a divide request.
REQ-005 SHALL have port req_ready, output, 1: sequencer can accept a request.
REQ-006 SHALL have port req_op, input, 4: EX opcode; only DIV (8) and REM (9) are valid.
REQ-007 SHALL have port req_unsigned, input, 1: unsigned operation when 1.
REQ-008 SHALL have port req_word, input, 1: 32-bit word operation when 1.
REQ-009 SHALL have port req_dividend, input, DATA_WIDTH: dividend (r1_val).
REQ-010 SHALL have port req_divisor, input, DATA_WIDTH: divisor (operand2).
REQ-011 SHALL have port req_dst_reg, input, 5: destination register tag.
REQ-012 SHALL have port flush, input, 1: abort the in-flight operation (branch redirect).
REQ-013 SHALL have port resp_valid, output, 1: result available.
REQ-014 SHALL have port resp_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port resp_result, output, DATA_WIDTH: quotient or remainder.
REQ-016 SHALL have port resp_dst_reg, output, 5: tag of the result.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-019 SHALL assert req_ready only in IDLE; accept when req_valid, req_ready, !flush and req_op is DIV or REM; ignore other opcodes.
REQ-020 SHALL, on accept, latch operands, op, flags and tag, then enter PREP.
REQ-021 PREP SHALL take absolute values (signed ops), record result signs, clear the iteration counter, load N = 32 (word) or 64 (otherwise), and enter ITER.
REQ-022 ITER SHALL perform one restoring shift-subtract step per cycle for exactly N cycles, then enter FIX.
REQ-023 FIX SHALL apply the sign fixups (quotient negative iff operand signs differ; remainder takes dividend sign), sign-extend word results from bit 31, and enter DONE.
REQ-024 Word ops SHALL use only bits [31:0] of the operands, sign- or zero-extended per req_unsigned.
REQ-025 DONE SHALL hold resp_valid high with resp_result and resp_dst_reg stable until resp_valid and resp_ready are both high, then enter IDLE.
REQ-026 Latency SHALL be N+3 cycles from the accept edge to the first resp_valid (67 for 64-bit, 35 for word).
REQ-027 Divide by zero SHALL produce quotient all-ones and remainder equal to the dividend (extended per REQ-024).
REQ-028 Signed overflow (most-negative / -1) SHALL produce quotient equal to the dividend and remainder 0.
REQ-029 flush SHALL force IDLE on the next edge from any state, including DONE, discarding the result; a request presented together with flush SHALL NOT be accepted.

Reset
REQ-030 reset low at a clock edge SHALL force IDLE, req_ready=1, resp_valid=0, busy=0, resp_result=0, resp_dst_reg=0, counter=0, including mid-operation.

Configuration
REQ-031 With DIV_EARLY_OUT_EN defined, PREP SHALL detect divide-by-zero and signed overflow and go directly to DONE, giving a latency of 2 cycles.
REQ-032 Without DIV_EARLY_OUT_EN, those cases SHALL run the full N+3-cycle path and produce the same results as REQ-027 and REQ-028.

Structure
REQ-033 The opcode constants (DIV, REM), the state enum and the default DATA_WIDTH SHALL be placed in the shared package pipeline_pkg.
REQ-034 The single restoring iteration SHALL be a combinational sub-module div_step (inputs: partial remainder, quotient, divisor; outputs: next partial remainder, next quotient).

Verification
REQ-035 64-bit unsigned DIV 100/7 -> resp_result=14, resp_valid first high 67 cycles after accept.
REQ-036 Word signed REM -7 % 2 -> resp_result=0xFFFF_FFFF_FFFF_FFFF, latency 35.
REQ-037 DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF and REM 5/0 -> 5; latency 2 with DIV_EARLY_OUT_EN and 67 without.
REQ-038 Signed DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
REQ-039 flush on the 10th ITER cycle -> IDLE next edge, resp_valid never high, req_ready=1.
REQ-040 resp_ready held low 5 cycles in DONE -> resp_valid, resp_result and resp_dst_reg stable, req_ready=0 until the handshake; reset low mid-ITER -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and types for the multi-cycle divide sequencer.
package pipeline_pkg;

    localparam int unsigned DefaultDataWidth = 64;

    localparam logic [3:0] OpDiv = 4'd8;
    localparam logic [3:0] OpRem = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } div_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/pipeline_div_seq_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial
// remainder and produces one quotient bit.
module div_step #(
    parameter int unsigned Width = 64
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] div_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] shifted;

    always_comb begin
        shifted = {rem_i, quo_i[Width-1]};
        if (shifted >= {1'b0, div_i}) begin
            // The difference is below the divisor, so it fits in Width bits.
            rem_o = shifted[Width-1:0] - div_i;
            quo_o = {quo_i[Width-2:0], 1'b1};
        end else begin
            rem_o = shifted[Width-1:0];
            quo_o = {quo_i[Width-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/pipeline_div_seq.sv
// Multi-cycle restoring DIV/REM sequencer (doubleword and 32-bit word forms).
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from PREP.
module pipeline_div_seq
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic                  req_unsigned,
    input  logic                  req_word,
    input  logic [DATA_WIDTH-1:0] req_dividend,
    input  logic [DATA_WIDTH-1:0] req_divisor,
    input  logic [4:0]            req_dst_reg,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [4:0]            resp_dst_reg,
    output logic                  busy
);

    localparam logic [6:0] FullIters = 7'(DATA_WIDTH);
    localparam logic [6:0] WordIters = 7'd32;

    div_state_e            state_q;
    logic                  req_ready_q, busy_q, resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_result_q;
    logic [4:0]            resp_dst_reg_q, dst_q;
    logic                  op_rem_q, unsigned_q, word_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, rem_q, quo_q, dvs_q;
    logic                  q_neg_q, r_neg_q;
    logic [6:0]            n_q, cnt_q;

    logic [DATA_WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, quo_init;
    logic [DATA_WIDTH-1:0] fix_raw, fix_res, step_rem, step_quo;
    logic                  a_neg, b_neg, div_zero;

    function automatic logic [DATA_WIDTH-1:0] word_ext(input logic word,
                                                       input logic [DATA_WIDTH-1:0] v);
        return word ? {{(DATA_WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        a_ext = a_q;
        b_ext = b_q;
        if (word_q) begin
            a_ext = {{(DATA_WIDTH-32){a_q[31] & ~unsigned_q}}, a_q[31:0]};
            b_ext = {{(DATA_WIDTH-32){b_q[31] & ~unsigned_q}}, b_q[31:0]};
        end
        a_neg    = ~unsigned_q & a_ext[DATA_WIDTH-1];
        b_neg    = ~unsigned_q & b_ext[DATA_WIDTH-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        // Word dividends start at the top so 32 steps leave the quotient in [31:0].
        quo_init = word_q ? {a_mag[31:0], {(DATA_WIDTH-32){1'b0}}} : a_mag;
        div_zero = (b_ext == '0);
        if (op_rem_q) begin
            fix_raw = r_neg_q ? -rem_q : rem_q;
        end else begin
            fix_raw = q_neg_q ? -quo_q : quo_q;
        end
        if (div_zero) begin
            fix_raw = op_rem_q ? a_ext : '1;
        end
        fix_res = word_ext(word_q, fix_raw);
    end

`ifdef DIV_EARLY_OUT_EN
    logic                  sgn_ovf;
    logic [DATA_WIDTH-1:0] min_neg, early_res;

    always_comb begin
        min_neg   = word_q ? {{(DATA_WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(DATA_WIDTH-1){1'b0}}};
        sgn_ovf   = ~unsigned_q && (a_ext == min_neg) && (&b_ext);
        early_res = div_zero ? (op_rem_q ? a_ext : '1) : (op_rem_q ? '0 : a_ext);
        early_res = word_ext(word_q, early_res);
    end
`endif

    div_step #(
        .Width (DATA_WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_result_q  <= '0;
            resp_dst_reg_q <= '0;
            cnt_q          <= '0;
            n_q            <= '0;
            dst_q          <= '0;
            op_rem_q       <= 1'b0;
            unsigned_q     <= 1'b0;
            word_q         <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
        end else if (flush) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && is_div_op(req_op)) begin
                        a_q         <= req_dividend;
                        b_q         <= req_divisor;
                        op_rem_q    <= (req_op == OpRem);
                        unsigned_q  <= req_unsigned;
                        word_q      <= req_word;
                        dst_q       <= req_dst_reg;
                        state_q     <= StPrep;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                StPrep: begin
                    rem_q   <= '0;
                    quo_q   <= quo_init;
                    dvs_q   <= b_mag;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    cnt_q   <= '0;
                    n_q     <= word_q ? WordIters : FullIters;
                    state_q <= StIter;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero || sgn_ovf) begin
                        state_q        <= StDone;
                        resp_valid_q   <= 1'b1;
                        resp_result_q  <= early_res;
                        resp_dst_reg_q <= dst_q;
                    end
`endif
                end
                StIter: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == n_q - 7'd1) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    resp_result_q  <= fix_res;
                    resp_dst_reg_q <= dst_q;
                    resp_valid_q   <= 1'b1;
                    state_q        <= StDone;
                end
                StDone: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_result  = resp_result_q;
    assign resp_dst_reg = resp_dst_reg_q;

endmodule

// File: tb/tb_pipeline_div_seq.sv
// Scoreboard bench for pipeline_div_seq: results, tags, latency, flush, stall and reset.
module tb_pipeline_div_seq;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_unsigned, req_word, flush;
    logic        resp_valid, resp_ready, busy;
    logic [3:0]  req_op;
    logic [63:0] req_dividend, req_divisor, resp_result;
    logic [4:0]  req_dst_reg, resp_dst_reg;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  dst;
        int          lat;
    } exp_t;

    exp_t sb[$];

`ifdef DIV_EARLY_OUT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    always #5 clk = ~clk;

    pipeline_div_seq #(
        .DATA_WIDTH (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_unsigned (req_unsigned),
        .req_word     (req_word),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_dst_reg  (req_dst_reg),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_dst_reg (resp_dst_reg),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic rem, input logic uns, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 32'd0) r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
            else if (uns) r32 = rem ? a32 % b32 : a32 / b32;
            else r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r = rem ? 64'd0 : a;
        else if (uns) r = rem ? a % b : a / b;
        else r = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return r;
    endfunction

    function automatic int exp_lat(input logic uns, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ae, be;
        logic        special;
        ae = word ? (uns ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]}) : a;
        be = word ? (uns ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]}) : b;
        special = (be == 64'd0) || (!uns && be == 64'hFFFF_FFFF_FFFF_FFFF &&
                  ae == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (special && EarlyEn) return 2;
        return word ? 35 : 67;
    endfunction

    // Presents a request, waits for the accept edge and records the expected response.
    task automatic issue(input logic [3:0] op, input logic uns, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst);
        exp_t e;
        int   guard;
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_unsigned = uns;
        req_word     = word;
        req_dividend = a;
        req_divisor  = b;
        req_dst_reg  = dst;
        guard        = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.data = ref_model(op == OpRem, uns, word, a, b);
        e.dst  = dst;
        e.lat  = exp_lat(uns, word, a, b);
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        int   lat;
        bit   seen;
        e    = sb.pop_front();
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) seen = 1'b1;
        end
        check("resp_seen", seen, 1);
        check("resp_result", resp_result, e.data);
        check("resp_dst", resp_dst_reg, e.dst);
        check("latency", lat, e.lat);
    endtask

    initial begin
        exp_t        e;
        bit          seen;
        logic [3:0]  rop;
        logic        runs, rword;
        logic [63:0] ra, rb;

        reset = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_unsigned = 1'b0; req_word = 1'b0;
        req_dividend = '0; req_divisor = '0; req_dst_reg = '0; flush = 1'b0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", resp_result, 0);
        check("rst_dst", resp_dst_reg, 0);
        @(negedge clk) reset = 1'b1;

        issue(OpDiv, 1'b1, 1'b0, 64'd100, 64'd7, 5'd3);                      collect();
        issue(OpRem, 1'b0, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002, 5'd4);
        collect();
        issue(OpDiv, 1'b0, 1'b0, 64'd5, 64'd0, 5'd6);                        collect();
        issue(OpRem, 1'b0, 1'b0, 64'd5, 64'd0, 5'd7);                        collect();
        issue(OpDiv, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
        collect();
        issue(OpRem, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
        collect();
        issue(OpDiv, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10);
        collect();
        issue(OpRem, 1'b1, 1'b1, 64'hFFFF_0000_0000_0064, 64'd0, 5'd11);         collect();

        for (int i = 0; i < 8; i++) begin
            rop   = $urandom_range(0, 1) ? OpRem : OpDiv;
            runs  = 1'($urandom_range(0, 1));
            rword = 1'($urandom_range(0, 1));
            ra    = {$urandom(), $urandom()};
            rb    = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()}
                                                : 64'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            issue(rop, runs, rword, ra, rb, 5'(i + 12));
            collect();
        end

        // Unsupported opcode must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        check("badop_busy", busy, 0);
        check("badop_ready", req_ready, 1);
        req_valid = 1'b0;

        // Request coinciding with flush must not be accepted.
        @(negedge clk);
        req_valid = 1'b1; req_op = OpDiv; flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flushreq_busy", busy, 0);
        check("flushreq_ready", req_ready, 1);

        // Flush during the 10th ITER cycle.
        issue(OpDiv, 1'b1, 1'b0, 64'd123456789, 64'd10, 5'd30);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", req_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_valid", resp_valid, 0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", seen, 0);

        // Consumer stalls for 5 cycles in DONE.
        resp_ready = 1'b0;
        issue(OpDiv, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd21);
        e = sb[0];
        collect();
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_valid", resp_valid, 1);
            check("stall_result", resp_result, e.data);
            check("stall_dst", resp_dst_reg, e.dst);
            check("stall_ready", req_ready, 0);
        end
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid", resp_valid, 0);
        check("hs_ready", req_ready, 1);

        // Reset asserted mid-ITER.
        issue(OpDiv, 1'b1, 1'b0, 64'd999, 64'd3, 5'd25);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_valid", resp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", resp_result, 0);
        check("midrst_dst", resp_dst_reg, 0);
        reset = 1'b1;

        issue(OpRem, 1'b1, 1'b0, 64'd100, 64'd7, 5'd1);
        collect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
